// File: rtl/itch_axi_regs_pkg.sv
// Register map, entry layout and status bit positions for the ITCH capture block.
// Shared by itch_msg_fifo and itch_axi_msg_fifo_regs.
package itch_axi_regs_pkg;

   localparam logic [7:0] OFF_CTRL      = 8'h00;
   localparam logic [7:0] OFF_STATUS    = 8'h04;
   localparam logic [7:0] OFF_POP       = 8'h08;
   localparam logic [7:0] OFF_OVF       = 8'h0C;
   localparam logic [7:0] OFF_THRESH    = 8'h10;
   localparam logic [7:0] OFF_H_TYPE    = 8'h20;
   localparam logic [7:0] OFF_H_REF_LO  = 8'h24;
   localparam logic [7:0] OFF_H_REF_HI  = 8'h28;
   localparam logic [7:0] OFF_H_SIDE    = 8'h2C;
   localparam logic [7:0] OFF_H_SHARES  = 8'h30;
   localparam logic [7:0] OFF_H_PRICE   = 8'h34;
   localparam logic [7:0] OFF_H_TS_LO   = 8'h38;
   localparam logic [7:0] OFF_H_TS_HI   = 8'h3C;
   localparam logic [7:0] OFF_TYPE_BASE = 8'h40;

   localparam int TYPE_W   = 4;
   localparam int REF_W    = 64;
   localparam int SIDE_W   = 1;
   localparam int SHARES_W = 32;
   localparam int PRICE_W  = 32;
   localparam int TS_W     = 48;
   localparam int ENTRY_W  = TYPE_W + REF_W + SIDE_W
                           + SHARES_W + PRICE_W + TS_W;

   localparam int STAT_EMPTY     = 0;
   localparam int STAT_FULL      = 1;
   localparam int STAT_COUNT_LSB = 8;

   localparam int CTRL_ENABLE = 0;
   localparam int CTRL_CLEAR  = 1;

   localparam logic [31:0] RD_UNMAPPED = 32'hDEAD_BEEF;

   typedef struct packed {
      logic [TYPE_W-1:0]   mtype;
      logic [REF_W-1:0]    order_ref;
      logic [SIDE_W-1:0]   side;
      logic [SHARES_W-1:0] shares;
      logic [PRICE_W-1:0]  price;
      logic [TS_W-1:0]     ts;
   } msg_entry_t;

endpackage

// File: rtl/itch_msg_fifo.sv
// First-word-fall-through sync FIFO with flush; head entry is always on dout.
// A push into a full FIFO is only taken when a pop happens in the same cycle.
module itch_msg_fifo
   import itch_axi_regs_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int WIDTH = ENTRY_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             wr_en;
   logic             rd_en;

   assign empty = (count == '0);
   assign full  = (count == (AW+1)'(DEPTH));
   assign rd_en = pop & ~empty;
   assign wr_en = push & (~full | rd_en);
   assign dout  = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (wr_en && !flush)
         mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en)
            wr_ptr <= wr_ptr + 1'b1;
         if (rd_en)
            rd_ptr <= rd_ptr + 1'b1;
         unique case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/itch_axi_msg_fifo_regs.sv
// AXI-Lite register front end for the ITCH message capture FIFO and counters.
// Optional irq output enabled with macro ITCH_AXI_MSG_IRQ_EN.
module itch_axi_msg_fifo_regs
   import itch_axi_regs_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 8,
   parameter int DEPTH              = 16,
   parameter int NUM_TYPES          = 16
) (
   input  logic                            S_AXI_ACLK,
   input  logic                            S_AXI_ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   input  logic                            msg_valid,
   input  logic [3:0]                      msg_type,
   input  logic [63:0]                     msg_order_ref,
   input  logic                            msg_side,
   input  logic [31:0]                     msg_shares,
   input  logic [31:0]                     msg_price,
   input  logic [47:0]                     msg_timestamp
`ifdef ITCH_AXI_MSG_IRQ_EN
  ,output logic                            irq
`endif
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic              awready_q;
   logic              bvalid_q;
   logic              arready_q;
   logic              rvalid_q;
   logic [31:0]       rdata_q;
   logic              enable_q;
   logic [31:0]       ovf_q;
   logic [31:0]       type_cnt [NUM_TYPES];
   logic [31:0]       thresh_rd;
   logic [31:0]       rd_mux;
   logic [31:0]       status;
   logic [7:0]        wr_off;
   logic [7:0]        rd_off;
   logic              wr_in;
   logic              rd_in;
   logic              wr_acc;
   logic              ar_acc;
   logic              wr_ctrl;
   logic              clear;
   logic              pop_req;
   logic              msg_en;
   logic              drop;
   logic [CW-1:0]     fcount;
   logic              ffull;
   logic              fempty;
   msg_entry_t        din;
   msg_entry_t        head;
   msg_entry_t        hv;
   logic              unused_sigs;

   assign unused_sigs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_WSTRB,
                          S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                          S_AXI_WDATA};

   assign S_AXI_AWREADY = awready_q;
   assign S_AXI_WREADY  = awready_q;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_BRESP   = 2'b00;
   assign S_AXI_ARREADY = arready_q;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = 2'b00;

   assign wr_off = {S_AXI_AWADDR[7:2], 2'b00};
   assign rd_off = {S_AXI_ARADDR[7:2], 2'b00};
   assign wr_in  = ((S_AXI_AWADDR >> 8) == '0);
   assign rd_in  = ((S_AXI_ARADDR >> 8) == '0);

   assign wr_acc  = S_AXI_AWVALID & S_AXI_WVALID & awready_q;
   assign ar_acc  = S_AXI_ARVALID & arready_q;
   assign wr_ctrl = wr_acc & wr_in & (wr_off == OFF_CTRL);
   assign clear   = wr_ctrl & S_AXI_WDATA[CTRL_CLEAR];
   assign pop_req = wr_acc & wr_in & (wr_off == OFF_POP);
   assign msg_en  = msg_valid & enable_q;
   assign drop    = msg_en & ffull & ~pop_req;

   assign din = {msg_type, msg_order_ref, msg_side,
                 msg_shares, msg_price, msg_timestamp};
   assign hv  = fempty ? '0 : head;

   itch_msg_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk   (S_AXI_ACLK),
      .rst_n (S_AXI_ARESETN),
      .flush (clear),
      .push  (msg_en),
      .pop   (pop_req),
      .din   (din),
      .dout  (head),
      .count (fcount),
      .full  (ffull),
      .empty (fempty)
   );

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         awready_q <= 1'b0;
         bvalid_q  <= 1'b0;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
      end else begin
         // single-cycle ready pulse; never accept while a B beat is pending
         awready_q <= S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q & ~awready_q;
         if (wr_acc)
            bvalid_q <= 1'b1;
         else if (S_AXI_BREADY)
            bvalid_q <= 1'b0;
         arready_q <= S_AXI_ARVALID & ~arready_q & ~rvalid_q;
         if (ar_acc) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_mux;
         end else if (S_AXI_RREADY) begin
            rvalid_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         enable_q <= 1'b0;
         ovf_q    <= '0;
         for (int t = 0; t < NUM_TYPES; t++)
            type_cnt[t] <= '0;
      end else begin
         if (wr_ctrl)
            enable_q <= S_AXI_WDATA[CTRL_ENABLE];
         if (clear)
            ovf_q <= '0;
         else if (drop && ovf_q != '1)
            ovf_q <= ovf_q + 1'b1;
         for (int t = 0; t < NUM_TYPES; t++) begin
            if (clear)
               type_cnt[t] <= '0;
            else if (msg_en && msg_type == 4'(t))
               type_cnt[t] <= type_cnt[t] + 1'b1;
         end
      end
   end

`ifdef ITCH_AXI_MSG_IRQ_EN
   logic [31:0] thresh_q;

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         thresh_q <= 32'd1;
         irq      <= 1'b0;
      end else begin
         if (wr_acc && wr_in && wr_off == OFF_THRESH)
            thresh_q <= S_AXI_WDATA;
         irq <= (32'(fcount) >= thresh_q) & (thresh_q != '0);
      end
   end

   assign thresh_rd = thresh_q;
`else
   assign thresh_rd = 32'd0;
`endif

   always_comb begin
      status = {15'd0, 9'(fcount), 6'd0, ffull, fempty};
   end

   always_comb begin
      rd_mux = RD_UNMAPPED;
      if (rd_in) begin
         case (rd_off)
            OFF_CTRL:     rd_mux = {31'd0, enable_q};
            OFF_STATUS:   rd_mux = status;
            OFF_POP:      rd_mux = 32'd0;
            OFF_OVF:      rd_mux = ovf_q;
            OFF_THRESH:   rd_mux = thresh_rd;
            OFF_H_TYPE:   rd_mux = {28'd0, hv.mtype};
            OFF_H_REF_LO: rd_mux = hv.order_ref[31:0];
            OFF_H_REF_HI: rd_mux = hv.order_ref[63:32];
            OFF_H_SIDE:   rd_mux = {31'd0, hv.side};
            OFF_H_SHARES: rd_mux = hv.shares;
            OFF_H_PRICE:  rd_mux = hv.price;
            OFF_H_TS_LO:  rd_mux = hv.ts[31:0];
            OFF_H_TS_HI:  rd_mux = {16'd0, hv.ts[47:32]};
            default: begin
               if (rd_off[7:6] == OFF_TYPE_BASE[7:6] &&
                   {1'b0, rd_off[5:2]} < 5'(NUM_TYPES))
                  rd_mux = type_cnt[rd_off[5:2]];
            end
         endcase
      end
   end

endmodule

// File: tb/tb_itch_axi_msg_fifo_regs.sv
// Directed bench for itch_axi_msg_fifo_regs (DEPTH 16, NUM_TYPES 15).
// irq checks compile in when ITCH_AXI_MSG_IRQ_EN is defined.
module tb_itch_axi_msg_fifo_regs;

   logic        S_AXI_ACLK = 1'b0;
   logic        S_AXI_ARESETN;
   logic [7:0]  S_AXI_AWADDR;
   logic [2:0]  S_AXI_AWPROT;
   logic        S_AXI_AWVALID;
   logic        S_AXI_AWREADY;
   logic [31:0] S_AXI_WDATA;
   logic [3:0]  S_AXI_WSTRB;
   logic        S_AXI_WVALID;
   logic        S_AXI_WREADY;
   logic [1:0]  S_AXI_BRESP;
   logic        S_AXI_BVALID;
   logic        S_AXI_BREADY;
   logic [7:0]  S_AXI_ARADDR;
   logic [2:0]  S_AXI_ARPROT;
   logic        S_AXI_ARVALID;
   logic        S_AXI_ARREADY;
   logic [31:0] S_AXI_RDATA;
   logic [1:0]  S_AXI_RRESP;
   logic        S_AXI_RVALID;
   logic        S_AXI_RREADY;
   logic        msg_valid;
   logic [3:0]  msg_type;
   logic [63:0] msg_order_ref;
   logic        msg_side;
   logic [31:0] msg_shares;
   logic [31:0] msg_price;
   logic [47:0] msg_timestamp;
`ifdef ITCH_AXI_MSG_IRQ_EN
   logic        irq;
`endif

   int tests = 0;
   int fails = 0;

   always #5 S_AXI_ACLK = ~S_AXI_ACLK;

   itch_axi_msg_fifo_regs #(
      .C_S_AXI_DATA_WIDTH (32),
      .C_S_AXI_ADDR_WIDTH (8),
      .DEPTH              (16),
      .NUM_TYPES          (15)
   ) dut (
      .S_AXI_ACLK    (S_AXI_ACLK),
      .S_AXI_ARESETN (S_AXI_ARESETN),
      .S_AXI_AWADDR  (S_AXI_AWADDR),
      .S_AXI_AWPROT  (S_AXI_AWPROT),
      .S_AXI_AWVALID (S_AXI_AWVALID),
      .S_AXI_AWREADY (S_AXI_AWREADY),
      .S_AXI_WDATA   (S_AXI_WDATA),
      .S_AXI_WSTRB   (S_AXI_WSTRB),
      .S_AXI_WVALID  (S_AXI_WVALID),
      .S_AXI_WREADY  (S_AXI_WREADY),
      .S_AXI_BRESP   (S_AXI_BRESP),
      .S_AXI_BVALID  (S_AXI_BVALID),
      .S_AXI_BREADY  (S_AXI_BREADY),
      .S_AXI_ARADDR  (S_AXI_ARADDR),
      .S_AXI_ARPROT  (S_AXI_ARPROT),
      .S_AXI_ARVALID (S_AXI_ARVALID),
      .S_AXI_ARREADY (S_AXI_ARREADY),
      .S_AXI_RDATA   (S_AXI_RDATA),
      .S_AXI_RRESP   (S_AXI_RRESP),
      .S_AXI_RVALID  (S_AXI_RVALID),
      .S_AXI_RREADY  (S_AXI_RREADY),
      .msg_valid     (msg_valid),
      .msg_type      (msg_type),
      .msg_order_ref (msg_order_ref),
      .msg_side      (msg_side),
      .msg_shares    (msg_shares),
      .msg_price     (msg_price),
      .msg_timestamp (msg_timestamp)
`ifdef ITCH_AXI_MSG_IRQ_EN
     ,.irq           (irq)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wait_b();
      int n = 0;
      @(negedge S_AXI_ACLK);
      while (!S_AXI_BVALID && n < 50) begin
         @(negedge S_AXI_ACLK);
         n++;
      end
      chk("bvalid_seen", {31'd0, S_AXI_BVALID}, 32'd1);
      chk("bresp", {30'd0, S_AXI_BRESP}, 32'd0);
      S_AXI_BREADY = 1'b1;
      @(posedge S_AXI_ACLK);
      #1 S_AXI_BREADY = 1'b0;
   endtask

   task automatic wait_aw();
      int n = 0;
      @(negedge S_AXI_ACLK);
      while (!S_AXI_AWREADY && n < 50) begin
         @(negedge S_AXI_ACLK);
         n++;
      end
      chk("awready_seen", {31'd0, S_AXI_AWREADY}, 32'd1);
   endtask

   task automatic axi_write(input logic [7:0] a, input logic [31:0] d);
      S_AXI_AWADDR  = a;
      S_AXI_WDATA   = d;
      S_AXI_AWVALID = 1'b1;
      S_AXI_WVALID  = 1'b1;
      wait_aw();
      @(posedge S_AXI_ACLK);
      #1;
      S_AXI_AWVALID = 1'b0;
      S_AXI_WVALID  = 1'b0;
      wait_b();
   endtask

   task automatic axi_read(input logic [7:0] a, output logic [31:0] d);
      int n = 0;
      S_AXI_ARADDR  = a;
      S_AXI_ARVALID = 1'b1;
      @(negedge S_AXI_ACLK);
      while (!S_AXI_ARREADY && n < 50) begin
         @(negedge S_AXI_ACLK);
         n++;
      end
      chk("arready_seen", {31'd0, S_AXI_ARREADY}, 32'd1);
      @(posedge S_AXI_ACLK);
      #1;
      S_AXI_ARVALID = 1'b0;
      S_AXI_RREADY  = 1'b1;
      n = 0;
      @(negedge S_AXI_ACLK);
      while (!S_AXI_RVALID && n < 50) begin
         @(negedge S_AXI_ACLK);
         n++;
      end
      d = S_AXI_RVALID ? S_AXI_RDATA : 32'hxxxx_xxxx;
      @(posedge S_AXI_ACLK);
      #1 S_AXI_RREADY = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [7:0] a,
                         input logic [31:0] exp);
      logic [31:0] d;
      axi_read(a, d);
      chk(tag, d, exp);
   endtask

   task automatic set_msg(input logic [3:0] t, input logic [31:0] p);
      msg_type      = t;
      msg_price     = p;
      msg_shares    = 32'd100 + p;
      msg_side      = p[0];
      msg_order_ref = 64'h1122_3344_5566_7788;
      msg_timestamp = 48'hABCD_0102_0304;
   endtask

   task automatic push(input logic [3:0] t, input logic [31:0] p);
      set_msg(t, p);
      msg_valid = 1'b1;
      @(posedge S_AXI_ACLK);
      #1 msg_valid = 1'b0;
   endtask

   initial begin
      logic [31:0] d;
      int sum;
      S_AXI_ARESETN = 1'b0;
      S_AXI_AWADDR  = '0;
      S_AXI_AWPROT  = '0;
      S_AXI_AWVALID = 1'b0;
      S_AXI_WDATA   = '0;
      S_AXI_WSTRB   = 4'hF;
      S_AXI_WVALID  = 1'b0;
      S_AXI_BREADY  = 1'b0;
      S_AXI_ARADDR  = '0;
      S_AXI_ARPROT  = '0;
      S_AXI_ARVALID = 1'b0;
      S_AXI_RREADY  = 1'b0;
      msg_valid     = 1'b0;
      set_msg(4'd0, 32'd0);
      repeat (3) @(posedge S_AXI_ACLK);
      chk("rst_axi_outs",
          {27'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RVALID}, 32'd0);
      @(negedge S_AXI_ACLK);
      S_AXI_ARESETN = 1'b1;
      @(posedge S_AXI_ACLK);
      #1;

      rd_chk("status_reset", 8'h04, 32'h0000_0001);
      rd_chk("unmapped_7c",  8'h7C, 32'hDEAD_BEEF);
      rd_chk("unmapped_14",  8'h14, 32'hDEAD_BEEF);
      rd_chk("ctrl_reset",   8'h00, 32'h0);
      rd_chk("ovf_reset",    8'h0C, 32'h0);
      rd_chk("head_empty",   8'h34, 32'h0);
`ifdef ITCH_AXI_MSG_IRQ_EN
      rd_chk("thresh_reset", 8'h10, 32'd1);
`else
      rd_chk("thresh_absent", 8'h10, 32'd0);
`endif

      // disabled: message ignored entirely
      push(4'd3, 32'h55);
      rd_chk("disabled_status", 8'h04, 32'h1);
      rd_chk("disabled_cnt3",   8'h4C, 32'h0);

      axi_write(8'h00, 32'h1);
      rd_chk("ctrl_en", 8'h00, 32'h1);
      push(4'd3, 32'h1234);
      rd_chk("status_one",  8'h04, 32'h0000_0100);
      rd_chk("head_price",  8'h34, 32'h0000_1234);
      rd_chk("cnt_type3",   8'h4C, 32'd1);
      rd_chk("head_type",   8'h20, 32'd3);
      rd_chk("head_ref_lo", 8'h24, 32'h5566_7788);
      rd_chk("head_ref_hi", 8'h28, 32'h1122_3344);
      rd_chk("head_side",   8'h2C, 32'd0);
      rd_chk("head_shares", 8'h30, 32'd100 + 32'h1234);
      rd_chk("head_ts_lo",  8'h38, 32'h0102_0304);
      rd_chk("head_ts_hi",  8'h3C, 32'h0000_ABCD);

      axi_write(8'h08, 32'h0);
      rd_chk("pop_to_empty", 8'h04, 32'h1);
      axi_write(8'h08, 32'hFFFF_FFFF);
      rd_chk("pop_on_empty", 8'h04, 32'h1);

      axi_write(8'h00, 32'h3);
      rd_chk("clear_cnt3", 8'h4C, 32'd0);
      rd_chk("clear_en",   8'h00, 32'h1);

      for (int i = 0; i < 18; i++)
         push(4'(i % 4), 32'(i));
      rd_chk("status_full", 8'h04, 32'h0000_1002);
      rd_chk("ovf_two",     8'h0C, 32'd2);
      rd_chk("head_first",  8'h34, 32'd0);
      sum = 0;
      for (int t = 0; t < 4; t++) begin
         axi_read(8'(8'h40 + 4 * t), d);
         sum += int'(d);
      end
      chk("type_sum", 32'(sum), 32'd18);
      rd_chk("cnt_type0", 8'h40, 32'd5);
      rd_chk("cnt_type2", 8'h48, 32'd4);

      // type 15 is beyond NUM_TYPES: dropped at full, never counted
      push(4'd15, 32'h77);
      rd_chk("ovf_three",  8'h0C, 32'd3);
      rd_chk("cnt_type14", 8'h78, 32'd0);
      rd_chk("type15_unmapped", 8'h7C, 32'hDEAD_BEEF);

      // POP accepted in the same cycle as msg_valid while full
      S_AXI_AWADDR  = 8'h08;
      S_AXI_WDATA   = 32'h0;
      S_AXI_AWVALID = 1'b1;
      S_AXI_WVALID  = 1'b1;
      wait_aw();
      set_msg(4'd5, 32'h99);
      msg_valid = 1'b1;
      @(posedge S_AXI_ACLK);
      #1;
      msg_valid     = 1'b0;
      S_AXI_AWVALID = 1'b0;
      S_AXI_WVALID  = 1'b0;
      wait_b();
      rd_chk("simul_status", 8'h04, 32'h0000_1002);
      rd_chk("simul_ovf",    8'h0C, 32'd3);
      rd_chk("simul_head",   8'h34, 32'd1);
      rd_chk("simul_cnt5",   8'h54, 32'd1);

      for (int i = 0; i < 11; i++)
         axi_write(8'h08, 32'h0);
      rd_chk("five_left",  8'h04, 32'h0000_0500);
      rd_chk("five_head",  8'h34, 32'd12);
      axi_write(8'h00, 32'h3);
      rd_chk("clr_status", 8'h04, 32'h1);
      rd_chk("clr_ovf",    8'h0C, 32'd0);
      rd_chk("clr_cnt0",   8'h40, 32'd0);
      rd_chk("clr_cnt5",   8'h54, 32'd0);
      rd_chk("clr_head",   8'h34, 32'd0);

`ifdef ITCH_AXI_MSG_IRQ_EN
      axi_write(8'h10, 32'd4);
      rd_chk("thresh_set", 8'h10, 32'd4);
      for (int i = 0; i < 3; i++)
         push(4'd1, 32'(i));
      repeat (2) @(posedge S_AXI_ACLK);
      #1 chk("irq_below", {31'd0, irq}, 32'd0);
      push(4'd1, 32'd3);
      repeat (2) @(posedge S_AXI_ACLK);
      #1 chk("irq_at_thresh", {31'd0, irq}, 32'd1);
      axi_write(8'h08, 32'h0);
      repeat (2) @(posedge S_AXI_ACLK);
      #1 chk("irq_after_pop", {31'd0, irq}, 32'd0);
`else
      axi_write(8'h10, 32'd4);
      rd_chk("thresh_ignored", 8'h10, 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/itch_axi_msg_fifo_regs.md
ITCH_AXI_MSG_FIFO_REGS -- requirements
Module: itch_axi_msg_fifo_regs

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32: AXI-Lite data width; only 32 supported.
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 8: byte address width.
REQ-003 SHALL have parameter DEPTH, default 16: capture FIFO entries; power of 2, 2..256.
REQ-004 SHALL have parameter NUM_TYPES, default 16: per-type counters; 1..16.
REQ-005 SHALL have port S_AXI_ACLK  in  1  single clock; all logic on rising edge.
REQ-006 SHALL have port S_AXI_ARESETN  in  1  asynchronous active-low reset.
REQ-007 SHALL have port group S_AXI_AW{ADDR,PROT,VALID}/AWREADY  in/out  ADDR_W,3,1/1  write address.
REQ-008 SHALL have port group S_AXI_W{DATA,STRB,VALID}/WREADY  in/out  32,4,1/1  write data.
REQ-009 SHALL have port group S_AXI_B{RESP,VALID}/BREADY  out/in  2,1/1  write response.
REQ-010 SHALL have port group S_AXI_AR{ADDR,PROT,VALID}/ARREADY  in/out  ADDR_W,3,1/1  read address.
REQ-011 SHALL have port group S_AXI_R{DATA,RESP,VALID}/RREADY  out/in  32,2,1/1  read data.
REQ-012 SHALL have port msg_valid  in  1  one-cycle pulse per parsed message.
REQ-013 SHALL have ports msg_type 4, msg_order_ref 64, msg_side 1, msg_shares 32, msg_price 32, msg_timestamp 48  in  sampled when msg_valid=1.

Function
REQ-014 Word map: 0x00 CTRL RW (bit0 ENABLE, bit1 CLEAR self-clearing); 0x04 STATUS RO ({count[8:0] at 8+, full bit1, empty bit0}); 0x08 POP WO; 0x0C OVF_CNT RO; 0x10 IRQ_THRESH RW.
REQ-015 Head-entry view, RO: 0x20 type, 0x24/0x28 order_ref lo/hi, 0x2C side, 0x30 shares, 0x34 price, 0x38 ts[31:0], 0x3C {16'd0, ts[47:32]}; all read 0 when empty.
REQ-016 Per-type counters RO at 0x40+4*t for t<NUM_TYPES; other unmapped reads return 0xDEADBEEF; all RRESP/BRESP = OKAY.
REQ-017 Write: AWREADY and WREADY assert together for one cycle only when AWVALID, WVALID both high and no B outstanding; BVALID next cycle, held until BREADY.
REQ-018 Read: ARREADY one cycle after ARVALID; RDATA/RVALID registered one cycle later, held until RREADY; RDATA sampled at accept.
REQ-019 Push: msg_valid & ENABLE & (!full | pop same cycle) writes entry at tail; latency 1 cycle to visible in STATUS/head.
REQ-020 Drop: msg_valid & ENABLE & full & no pop -> entry discarded, OVF_CNT +1 saturating at 0xFFFFFFFF.
REQ-021 Pop: accepted write to POP (any data) removes head when !empty; on empty ignored, no underflow.
REQ-022 Simultaneous push and pop: both occur, count unchanged, including at full.
REQ-023 Type counter t: +1 on every msg_valid & ENABLE with msg_type==t, regardless of FIFO state; 32-bit wrap; types >= NUM_TYPES not counted.
REQ-024 CLEAR write: next cycle FIFO empty, pointers 0, OVF_CNT and type counters 0; overrides push/pop that cycle; ENABLE takes written bit0.
REQ-025 WSTRB ignored; full 32-bit writes assumed for all RW registers.

Reset
REQ-026 Async assert: all AXI outputs 0, ARREADY/AWREADY/WREADY 0, FIFO empty, counters 0, CTRL 0 (disabled), IRQ_THRESH 1.
REQ-027 Reset mid-transaction abandons it; no B/R beat issued after release for it.

Configuration
REQ-028 Macro ITCH_AXI_MSG_IRQ_EN defined: output port irq (1 bit) = registered (count >= IRQ_THRESH) & (IRQ_THRESH != 0), updates 1 cycle after count change.
REQ-029 Macro undefined: irq port absent, 0x10 reads 0, writes ignored.

Structure
REQ-030 Package itch_axi_regs_pkg: register offsets, entry field widths, ENTRY_W (181), STATUS bit positions.
REQ-031 Sub-module itch_msg_fifo: parametrised DEPTH x ENTRY_W sync FIFO with push/pop/flush, count, full, empty, head data (first-word-fall-through).

Verification
REQ-032 Reset, read 0x04 -> 0x00000001 (empty); read 0x7C -> 0xDEADBEEF.
REQ-033 Write CTRL=1, push type 3 price 0x1234 -> STATUS count 1; 0x34 reads 0x1234; 0x4C reads 1.
REQ-034 DEPTH=16, push 18 msgs no pop -> STATUS full, count 16, OVF_CNT 2; 0x40+4*type sum 18.
REQ-035 Full FIFO, POP write same cycle as msg_valid -> count stays 16, OVF_CNT unchanged, head advances.
REQ-036 POP on empty -> STATUS still 0x1; CLEAR with 5 entries -> empty, all counters 0 next cycle.
REQ-037 IRQ_EN build, IRQ_THRESH=4, push 4 -> irq 1; one POP -> irq 0.
